// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared phase codes, default geometry and width helpers for the conv datapath
package conv_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_ACCUM = 2'd1,
        PH_FLUSH = 2'd2,
        PH_CLEAR = 2'd3
    } phase_t;

    localparam int DEF_NUM1    = 14;
    localparam int DEF_NUM2    = 5;
    localparam int DEF_CHANNEL = 6;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Output row length (and row count) of a valid convolution.
    function automatic int rows_of(input int num1, input int num2);
        return num1 + 1 - num2;
    endfunction

    // Accumulation steps needed to finish one output row.
    function automatic int ksteps_of(input int channel, input int num2);
        return channel * num2;
    endfunction

endpackage

// File: rtl/row_sum_ctrl_if.sv
// rtl/row_sum_ctrl_if.sv - upstream beat and downstream row handshakes of row_sum_ctrl
interface row_sum_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MOD counter with enable, synchronous clear and terminal flag
module wrap_counter
    import conv_pkg::*;
#(
    parameter  int MOD = 2,
    localparam int W   = cw(MOD)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(MOD - 1));

    // Clear has priority over counting; the count wraps to zero after MOD-1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/row_sum_ctrl.sv
// rtl/row_sum_ctrl.sv - sequencer producing row_sum control indices and row handshakes
module row_sum_ctrl
    import conv_pkg::*;
#(
    parameter  int WORDWIDTH = 32,
    parameter  int NUM1      = DEF_NUM1,
    parameter  int NUM2      = DEF_NUM2,
    parameter  int CHANNEL   = DEF_CHANNEL,
    localparam int ROWS      = rows_of(NUM1, NUM2),
    localparam int KSTEPS    = ksteps_of(CHANNEL, NUM2),
    localparam int C1W       = cw(KSTEPS + 1),
    localparam int C2W       = cw(ROWS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    output logic            busy,
    output logic            done,
    row_sum_ctrl_if.slave   bus,
    output logic [C1W-1:0]  count1,
    output logic [C2W-1:0]  count2,
    output logic [1:0]      count3,
    output logic [C2W-1:0]  row_idx
);

    if (WORDWIDTH < 1) begin : g_bad_wordwidth
        $error("row_sum_ctrl: WORDWIDTH must be at least 1");
    end

    phase_t state;
    phase_t state_nxt;

    logic start_frame;
    logic beat;
    logic c1_at_end;
    logic c1_is_clear;
    logic c2_last;
    logic row_last;

    assign start_frame = (state == PH_IDLE) && start;
    assign beat        = (state == PH_ACCUM) && bus.in_valid;
    assign c1_at_end   = (count1 == C1W'(KSTEPS - 1));

    // Column index: one step per accepted beat, restarted for every row.
    wrap_counter #(.MOD(ROWS)) u_count2 (
        .clk   (clk),
        .rstn  (rstn),
        .en    (beat),
        .clr   (start_frame || (state == PH_CLEAR)),
        .count (count2),
        .last  (c2_last)
    );

    // Step index: advances on column wrap but parks at KSTEPS-1 for the flush,
    // then steps to KSTEPS on the row handshake to command the buffer clear.
    wrap_counter #(.MOD(KSTEPS + 1)) u_count1 (
        .clk   (clk),
        .rstn  (rstn),
        .en    ((beat && c2_last && !c1_at_end) ||
                ((state == PH_FLUSH) && bus.out_ready)),
        .clr   (start_frame || c1_is_clear),
        .count (count1),
        .last  (c1_is_clear)
    );

    // Output row index: advances once per clear and wraps to 0 after the last row.
    wrap_counter #(.MOD(ROWS)) u_row (
        .clk   (clk),
        .rstn  (rstn),
        .en    (state == PH_CLEAR),
        .clr   (start_frame),
        .count (row_idx),
        .last  (row_last)
    );

    // Phase register; its encoding is the count3 code seen by row_sum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= PH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase transitions and phase-decoded handshake/status outputs.
    always_comb begin
        state_nxt     = state;
        busy          = (state != PH_IDLE);
        done          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        count3        = state;
        case (state)
            PH_IDLE: begin
                if (start) begin
                    state_nxt = PH_ACCUM;
                end
            end
            PH_ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && c2_last && c1_at_end) begin
                    state_nxt = PH_FLUSH;
                end
            end
            PH_FLUSH: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = PH_CLEAR;
                end
            end
            PH_CLEAR: begin
                done      = row_last;
                state_nxt = row_last ? PH_IDLE : PH_ACCUM;
            end
            default: begin
                state_nxt = PH_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_row_sum_ctrl.sv
// tb/tb_row_sum_ctrl.sv - scoreboard bench for row_sum_ctrl
module tb_row_sum_ctrl;
    import conv_pkg::*;

    localparam int ROWS   = 10;
    localparam int KSTEPS = 30;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] count1;
    logic [3:0] count2;
    logic [1:0] count3;
    logic [3:0] row_idx;

    logic       s_start;
    logic       s_busy;
    logic       s_done;
    logic [1:0] s_count1;
    logic [1:0] s_count2;
    logic [1:0] s_count3;
    logic [1:0] s_row_idx;

    row_sum_ctrl_if bus();
    row_sum_ctrl_if s_bus();

    row_sum_ctrl dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bus     (bus),
        .count1  (count1),
        .count2  (count2),
        .count3  (count3),
        .row_idx (row_idx)
    );

    row_sum_ctrl #(.NUM1(4), .NUM2(2), .CHANNEL(1)) dut_small (
        .clk     (clk),
        .rstn    (rstn),
        .start   (s_start),
        .busy    (s_busy),
        .done    (s_done),
        .bus     (s_bus),
        .count1  (s_count1),
        .count2  (s_count2),
        .count3  (s_count3),
        .row_idx (s_row_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c1;
        int c2;
        int row;
    } beat_t;

    beat_t beat_q[$];
    int    row_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    int first_ov = -1;
    int done_rel = -1;
    int acc0 = 0;
    bit done_seen = 0;
    bit mon_en = 0;
    bit ov_pending = 0;
    int iv_mode = 0;
    int or_mode = 0;
    bit tog = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        case (iv_mode)
            0:       bus.in_valid = 1'b1;
            1:       begin tog = !tog; bus.in_valid = tog; end
            default: bus.in_valid = ($urandom_range(0, 2) != 0);
        endcase
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 1) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    // A frame is ROWS rows; each row consumes beats in step-major, column-minor order.
    task automatic do_start();
        for (int r = 0; r < ROWS; r++) begin
            for (int n = 0; n < KSTEPS * ROWS; n++) begin
                beat_q.push_back('{c1: n / ROWS, c2: n % ROWS, row: r});
            end
            row_q.push_back(r);
        end
        cycle();
        start = 1'b1;
        if (iv_mode == 1) begin
            tog = 1'b1;
            bus.in_valid = 1'b1;
        end
        cycle();
        start = 1'b0;
        t0 = cyc;
        first_ov = -1;
        done_seen = 0;
        acc0 = 0;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin
            cycle();
            k++;
        end
        check("done_timeout", int'(done_seen), 1);
        cycle();
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_count3", int'(count3), 0);
        check("idle_count1", int'(count1), 0);
        check("idle_row_idx", int'(row_idx), 0);
    endtask

    task automatic wait_out_valid(input int budget);
        int k = 0;
        while (!bus.out_valid && k < budget) begin
            cycle();
            k++;
        end
        check("flush_timeout", int'(bus.out_valid), 1);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT takes a beat or hands off a row.
    always @(negedge clk) begin : monitor
        beat_t b;
        int    rel;
        if (mon_en) begin
            rel = cyc - t0 + 1;
            if (count3 == 2'd1 && row_idx == 4'd0) acc0++;
            if (bus.in_valid && bus.in_ready) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_count1", int'(count1), b.c1);
                    check("beat_count2", int'(count2), b.c2);
                    check("beat_row_idx", int'(row_idx), b.row);
                    check("beat_count3", int'(count3), 1);
                end
            end
            if (ov_pending && !bus.out_valid) check("out_valid_dropped", int'(bus.out_valid), 1);
            if (bus.out_valid) begin
                if (first_ov < 0) first_ov = rel;
                check("flush_in_ready", int'(bus.in_ready), 0);
                if (bus.out_ready) begin
                    if (row_q.size() == 0) begin
                        check("row_unexpected", 1, 0);
                    end else begin
                        check("row_row_idx", int'(row_idx), row_q.pop_front());
                        check("row_count1", int'(count1), KSTEPS - 1);
                        check("row_count2", int'(count2), 0);
                    end
                end
            end
            ov_pending = bus.out_valid && !bus.out_ready;
            if (count3 == 2'd3) check("clear_count1", int'(count1), KSTEPS);
            if (done) begin
                if (!done_seen) done_rel = rel;
                done_seen = 1;
                check("done_row_idx", int'(row_idx), ROWS - 1);
                check("done_beats_left", beat_q.size(), 0);
                check("done_rows_left", row_q.size(), 0);
            end
        end
    end

    initial begin
        int k;
        int hs;
        rstn = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        s_bus.in_valid = 1'b1;
        s_bus.out_ready = 1'b1;
        repeat (3) cycle();

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_count1", int'(count1), 0);
        check("rst_count2", int'(count2), 0);
        check("rst_count3", int'(count3), 0);
        check("rst_row_idx", int'(row_idx), 0);
        rstn = 1'b1;
        mon_en = 1;

        // Small geometry: ROWS=3, KSTEPS=2, always-ready handshakes.
        s_start = 1'b1;
        cycle();
        s_start = 1'b0;
        k = 1;
        hs = (s_bus.in_valid && s_bus.in_ready) ? 1 : 0;
        while (!s_done && k < 100) begin
            cycle();
            k++;
            if (s_bus.in_valid && s_bus.in_ready && !s_done) hs++;
        end
        check("small_done_cycle", k, 24);
        check("small_beats", hs, 18);
        cycle();
        check("small_idle", int'(s_busy), 0);

        // Free-flowing frame: exact timing of flush and done.
        iv_mode = 0;
        or_mode = 0;
        do_start();
        run_until_done(3100);
        check("first_out_valid_cycle", first_ov, 301);
        check("done_cycle", done_rel, 3020);

        // Toggling in_valid, plus a start pulse ignored in the middle of row 4.
        iv_mode = 1;
        do_start();
        k = 0;
        while (!(row_idx == 4'd4 && count3 == 2'd1) && k < 4000) begin
            cycle();
            k++;
        end
        check("reach_row4", int'(row_idx), 4);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("mid_start_row_idx", int'(row_idx), 4);
        check("mid_start_busy", int'(busy), 1);
        run_until_done(7000);
        check("toggle_row0_accum_cycles", acc0, 600);

        // Downstream stall of 50 cycles on row 0, then random traffic.
        iv_mode = 0;
        or_mode = 2;
        do_start();
        wait_out_valid(400);
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_in_ready", int'(bus.in_ready), 0);
            check("stall_count1", int'(count1), KSTEPS - 1);
            check("stall_row_idx", int'(row_idx), 0);
        end
        or_mode = 0;
        cycle();
        cycle();
        check("post_stall_count3", int'(count3), 3);
        check("post_stall_count1", int'(count1), KSTEPS);
        iv_mode = 2;
        or_mode = 1;
        run_until_done(10000);

        // Reset for one cycle in the middle of a flush.
        iv_mode = 0;
        or_mode = 2;
        do_start();
        wait_out_valid(400);
        rstn = 1'b0;
        mon_en = 0;
        cycle();
        rstn = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        check("midrst_count1", int'(count1), 0);
        check("midrst_count3", int'(count3), 0);
        check("midrst_row_idx", int'(row_idx), 0);
        beat_q.delete();
        row_q.delete();
        ov_pending = 0;
        mon_en = 1;
        iv_mode = 2;
        or_mode = 1;
        do_start();
        run_until_done(10000);

        check("final_beats_left", beat_q.size(), 0);
        check("final_rows_left", row_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
